// File: rtl/csa_accumulator_if.sv
// csa_accumulator_if: term input, clear and result handshake bundle for csa_accumulator.
// master = term producer / result consumer, slave = accumulator.
// CSA_ACC_TERM_COUNT_EN adds the out_count result field.
interface csa_accumulator_if #(
    parameter int ACC_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_sum;
    logic [15:0]      in_carry;
    logic             in_last;
    logic             clr;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_result;
    logic             busy;
`ifdef CSA_ACC_TERM_COUNT_EN
    logic [15:0]      out_count;
`endif

    modport master (
        output in_valid, in_sum, in_carry, in_last, clr, out_ready,
`ifdef CSA_ACC_TERM_COUNT_EN
        input  out_count,
`endif
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  in_valid, in_sum, in_carry, in_last, clr, out_ready,
`ifdef CSA_ACC_TERM_COUNT_EN
        output out_count,
`endif
        output in_ready, out_valid, out_result, busy
    );
endinterface

// File: rtl/csa_accumulator.sv
// csa_accumulator: carry-save accumulation of Sum/Carry term pairs (two 3:2 levels
// per beat), resolved on the last term by a chunked multi-cycle carry-propagate
// adder, result returned over valid/ready.
// Optional: CSA_ACC_TERM_COUNT_EN adds a saturating accepted-term counter (out_count).
module csa_accumulator #(
    parameter int ACC_W = 32,
    parameter int CHUNK = 8
) (
    input  logic               clk,
    input  logic               rst,
    csa_accumulator_if.slave   bus
);
    localparam int NCHUNK = ACC_W / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

    state_t           state, state_nx;
    logic [ACC_W-1:0] acc_s, acc_c, result;
    logic [KW-1:0]    k;
    logic             cy;

    logic             accept, last_chunk, out_hs;
    logic [ACC_W-1:0] base_s, base_c, tsum, tcar, s1, c1, c1s, s2, c2;
    logic [CHUNK:0]   csum;

    // Two 3:2 levels folding the term into the redundant accumulator, plus one CPA chunk.
    always_comb begin
        accept     = bus.in_valid && (state == ACCUM);
        out_hs     = bus.out_ready && (state == OUTPUT);
        last_chunk = (k == KW'(NCHUNK - 1));
        // a clear in the same beat lands before the term is added
        base_s     = bus.clr ? '0 : acc_s;
        base_c     = bus.clr ? '0 : acc_c;
        tsum       = ACC_W'(bus.in_sum);
        tcar       = ACC_W'(bus.in_carry) << 1;
        s1         = base_s ^ base_c ^ tsum;
        c1         = (base_s & base_c) | (base_s & tsum) | (base_c & tsum);
        c1s        = c1 << 1;
        s2         = s1 ^ c1s ^ tcar;
        c2         = (s1 & c1s) | (s1 & tcar) | (c1s & tcar);
        csum       = {1'b0, acc_s[k*CHUNK +: CHUNK]} + {1'b0, acc_c[k*CHUNK +: CHUNK]}
                   + (CHUNK+1)'(cy);
    end

    // Next-state: accumulate until the last term, resolve chunk by chunk, hold until taken.
    always_comb begin
        state_nx = state;
        case (state)
            ACCUM:   if (accept && bus.in_last) state_nx = RESOLVE;
            RESOLVE: if (last_chunk)            state_nx = OUTPUT;
            OUTPUT:  if (bus.out_ready)         state_nx = ACCUM;
            default:                            state_nx = ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_nx;
    end

    // Accumulator, resolve chunk index/carry and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_s  <= '0;
            acc_c  <= '0;
            result <= '0;
            k      <= '0;
            cy     <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc_s <= s2;
                        acc_c <= c2 << 1;
                        if (bus.in_last) begin
                            k  <= '0;
                            cy <= 1'b0;
                        end
                    end else if (bus.clr) begin
                        acc_s <= '0;
                        acc_c <= '0;
                    end
                end
                RESOLVE: begin
                    // top chunk's carry-out falls off: result wraps mod 2^ACC_W
                    result[k*CHUNK +: CHUNK] <= csum[CHUNK-1:0];
                    cy                       <= csum[CHUNK];
                    k                        <= k + 1'b1;
                end
                OUTPUT: begin
                    if (out_hs) begin
                        acc_s <= '0;
                        acc_c <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CSA_ACC_TERM_COUNT_EN
    logic [15:0] cnt, cnt_out;

    // Saturating count of accepted terms; snapshot taken as the result is entering OUTPUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            cnt_out <= '0;
        end else begin
            if (state == ACCUM) begin
                if (accept)       cnt <= bus.clr ? 16'd1 : ((cnt == 16'hFFFF) ? cnt : cnt + 16'd1);
                else if (bus.clr) cnt <= '0;
            end else if (out_hs) begin
                cnt <= '0;
            end
            if (state == RESOLVE && last_chunk) cnt_out <= cnt;
        end
    end

    assign bus.out_count = cnt_out;
`endif

    assign bus.in_ready   = (state == ACCUM);
    assign bus.out_valid  = (state == OUTPUT);
    assign bus.busy       = (state != ACCUM);
    assign bus.out_result = result;
endmodule

// File: tb/tb_csa_accumulator.sv
// tb_csa_accumulator: scoreboard bench; expected result (and term count) pushed on
// each accepted last term, popped when the DUT hands a result over.
module tb_csa_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csa_accumulator_if #(.ACC_W(32)) bus ();

    csa_accumulator #(.ACC_W(32), .CHUNK(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_chk = 0, n_pass = 0, rdy_miss = 0;
    logic [31:0] m_acc = '0;
    logic [15:0] m_cnt = '0;
    logic [31:0] exp_q[$];
    logic [15:0] cnt_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // present one term; model updated on the accepting edge
    task automatic send(input logic [15:0] s, input logic [15:0] c, input bit last, input bit cl);
        int n = 0;
        if (!bus.in_ready) rdy_miss++;
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!bus.in_ready) begin chk("send_timeout", 0, 1); return; end
        bus.in_valid = 1'b1; bus.in_sum = s; bus.in_carry = c;
        bus.in_last = last;  bus.clr = cl;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.clr = 1'b0;
        if (cl) begin m_acc = '0; m_cnt = '0; end
        m_acc = m_acc + {16'h0, s} + ({16'h0, c} << 1);
        if (m_cnt != 16'hFFFF) m_cnt++;
        if (last) begin
            exp_q.push_back(m_acc); cnt_q.push_back(m_cnt);
            m_acc = '0; m_cnt = '0;
        end
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
        ok = bus.out_valid;
        if (!ok) chk("valid_timeout", 0, 1);
    endtask

    // check the presented result against the scoreboard, then take it
    task automatic get_result(input string tag);
        bit ok;
        logic [15:0] ec;
        wait_valid(ok);
        if (!ok) return;
        if (exp_q.size() == 0) begin chk("sb_empty", 0, 1); return; end
        chk(tag, bus.out_result, exp_q.pop_front());
        ec = cnt_q.pop_front();
`ifdef CSA_ACC_TERM_COUNT_EN
        chk({tag, "_cnt"}, bus.out_count, ec);
`endif
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "_rdy"}, bus.in_ready, 1);
        chk({tag, "_ovl"}, bus.out_valid, 0);
    endtask

    initial begin
        int          err;
        logic [31:0] held;
        bit          ok;
        bus.in_valid = 0; bus.in_sum = 0; bus.in_carry = 0; bus.in_last = 0;
        bus.clr = 0; bus.out_ready = 0;

        // reset state
        repeat (2) @(posedge clk); #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.out_result, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // single term and latency: accept edge counts as edge 1, valid after edge 5
        send(16'h0003, 16'h0001, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            chk("lat_low", bus.out_valid, 0);
            @(posedge clk); #1;
        end
        chk("lat_high", bus.out_valid, 1);
        get_result("single");

        // long run: wraps mod 2^32 and saturates the term counter
        rdy_miss = 0;
        for (int i = 0; i < 70000; i++) send(16'hFFFF, 16'hFFFF, i == 69999, 0);
        chk("stress_rdy", rdy_miss, 0);
        get_result("stress");

        // backpressure
        send(16'h1234, 16'h0100, 1, 0);
        wait_valid(ok);
        held = bus.out_result;
        err = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_result !== held || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 ||
                bus.out_valid !== 1'b1) err++;
            @(posedge clk); #1;
        end
        chk("bp_hold", err, 0);
        get_result("bp");
        send(16'h0001, 16'h0000, 1, 0);
        get_result("bp_next");

        // clear together with the last term
        repeat (3) send(16'h0010, 16'h0000, 0, 0);
        send(16'h0002, 16'h0001, 1, 1);
        get_result("clr_last");

        // clear during resolve is ignored
        send(16'h0005, 16'h0000, 1, 0);
        bus.clr = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.clr = 1'b0;
        get_result("clr_resolve");

        // reset while chunk 2 is being resolved
        send(16'h0009, 16'h0000, 1, 0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("mid_rst_ovl", bus.out_valid, 0);
        chk("mid_rst_rdy", bus.in_ready, 1);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_res", bus.out_result, 0);
        exp_q.delete(); cnt_q.delete(); m_acc = '0; m_cnt = '0;
        @(negedge clk) rst = 1'b0;
        err = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) err++;
        end
        chk("mid_rst_noval", err, 0);
        send(16'h0007, 16'h0000, 1, 0);
        get_result("after_rst");

        // term counting, including clear with an accepted beat
        for (int i = 1; i <= 5; i++) send(16'(i), 16'(i * 3), i == 5, 0);
        get_result("count5");
        send(16'h0001, 16'h0000, 0, 0);
        send(16'h0001, 16'h0000, 0, 0);
        send(16'h0002, 16'h0002, 0, 1);
        send(16'h0004, 16'h0000, 0, 0);
        send(16'h0008, 16'h0001, 1, 0);
        get_result("count3");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
